expr_emitter: RTL
=================

Name: expr_emitter

Overview:
- Transmit side of the single-digit arithmetic expression character stream: serializes a packed expression into one ASCII character per handshake.
- Output grammar is digit (op digit)*, with digits '0'..'9' and op being '+' or '*'.
- Feeds the downstream expression recognizer and test stimulus paths; one expression per start command; valid/ready backpressure on the output.

Parameters:
- MAX_TERMS, 8, maximum number of digit operands per expression (>=2).
- CW, $clog2(MAX_TERMS+1), width of num_terms (4 at default).

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  load command, sampled only when busy=0.
- num_terms  input  CW  number of digits in the expression, legal 1..MAX_TERMS.
- digits  input  4*MAX_TERMS  digit k at [4k+3:4k]; term 0 is emitted first.
- ops  input  MAX_TERMS-1  op k between term k and term k+1; 0='+', 1='*'.
- out_char  output  8  ASCII character presented.
- out_valid  output  1  out_char valid.
- out_ready  input  1  consumer accepts out_char this cycle.
- busy  output  1  expression loaded and not yet fully accepted.
- done  output  1  one-cycle pulse after the last character is accepted.
- err  output  1  one-cycle pulse when an illegal start is rejected.

Behaviour:
- Reset (clr=1, asynchronous, any state): state=IDLE; out_char=8'h00; out_valid=0; busy=0; done=0; err=0; captured registers cleared. Any stream in progress is abandoned and no further characters are presented.
- Character mapping:
  - digit d is emitted as 8'h30+d.
  - op 0 is emitted as 8'h2B ('+'); op 1 is emitted as 8'h2A ('*').
- States:
  - IDLE: busy=0, out_valid=0, out_char=8'h00.
  - NUM: presenting digit at index idx.
  - OP: presenting op at index idx.
- IDLE with start=1:
  - Legal start (1<=num_terms<=MAX_TERMS and every used digit <=9): capture digits, ops and num_terms into internal registers; idx=0; go to NUM. Next cycle: out_valid=1, out_char=first digit, busy=1.
  - Illegal start: stay in IDLE; err=1 for the next cycle only; no characters presented.
  - Digits beyond num_terms are don't-care and are not checked.
- Hold rule: while out_valid=1 and out_ready=0, out_char and state stay stable.
- Handshake: out_valid and out_ready both 1 at a rising edge means the character is accepted.
- Transitions on accept:
  - NUM with idx<num_terms-1 -> OP, same idx.
  - OP -> NUM, idx+1.
  - NUM with idx=num_terms-1 -> IDLE; next cycle done=1, busy=0, out_valid=0.
- Throughput: no bubbles; with out_ready held at 1, one character per cycle, 2*num_terms-1 characters in total.
- start while busy=1 is ignored, including inputs and the legality check. start in the done cycle is accepted, since state is IDLE.
- Captured inputs are used throughout the stream; input changes after start do not affect the stream in progress.
- done and err are never both 1 in the same cycle. done is never asserted without a completed stream.
- num_terms=1 emits a single digit character and no ops.

Test Plan:
- Expression 1+2*3: num_terms=3, digits 1,2,3, ops 0,1, out_ready=1 -> chars 0x31,0x2B,0x32,0x2A,0x33 on 5 consecutive cycles starting 1 cycle after start; done on the 6th cycle; busy high for exactly 5 cycles.
- Backpressure on the same expression: out_ready low for 3 cycles while 0x2B is presented -> 0x2B held stable with out_valid=1; stream then resumes with 0x32; total of 5 accepts, then one done pulse.
- Single term 9 (num_terms=1) -> one char 0x39, then done; out_valid is never asserted with 0x2A or 0x2B.
- Illegal starts:
  - digit0=10 -> err pulse, out_valid stays 0.
  - num_terms=0 -> err pulse, out_valid stays 0.
  - num_terms=9 at default parameters -> err pulse, out_valid stays 0.
  - A following legal start then works normally.
- clr mid-stream: assert clr after the 2nd accepted char -> out_valid=0 and out_char=0 immediately; no done pulse; a new start afterwards emits from term 0.
- start and input changes while busy -> ignored, original stream completes unchanged. Chained check: feeding the output into the recognizer gives recognizer out=1 after every digit accept.

Source files
------------

// File: rtl/expr_emitter.sv
// -----------------------------------------------------------------------------
// expr_emitter
//   Sends a packed single-digit arithmetic expression out as a stream of
//   ASCII characters, one character per valid/ready handshake. The stream
//   follows the grammar digit (op digit)*. Digits go out as '0'..'9' and the
//   operators as '+' or '*'.
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous, active-high reset
//   start      load command; only looked at while busy=0
//   num_terms  number of digit operands, legal range 1..MAX_TERMS
//   digits     digit k sits at [4k+3:4k]; term 0 is sent first
//   ops        op k goes between term k and term k+1 (0='+', 1='*')
//   out_char   ASCII character currently presented
//   out_valid  out_char is valid
//   out_ready  consumer takes out_char this cycle
//   busy       an expression is loaded and has not been fully accepted yet
//   done       one-cycle pulse after the last character is accepted
//   err        one-cycle pulse when an illegal start is rejected
// -----------------------------------------------------------------------------
module expr_emitter #(
  parameter int MAX_TERMS = 8,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [CW-1:0]          num_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  output logic [7:0]             out_char,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam logic [7:0] CHAR_PLUS = 8'h2B;
  localparam logic [7:0] CHAR_MUL  = 8'h2A;

  typedef enum logic [1:0] {
    IDLE,
    NUM,
    OP
  } state_t;

  state_t                 state;
  logic [CW-1:0]          idx;
  logic [CW-1:0]          nt_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;

  logic                   start_legal;
  logic                   op_sel;
  logic [3:0]             digit_next;
  logic [CW-1:0]          idx_next;
  logic                   last_term;

  // A start is legal when the term count is in range and every digit that
  // will be used is a decimal digit. Digits past num_terms do not matter.
  // NOTE: every signal gets a default at the top of always_comb. Any path
  // that left one unassigned would infer a latch.
  always_comb begin
    start_legal = (num_terms != '0) && (num_terms <= CW'(MAX_TERMS));
    for (int k = 0; k < MAX_TERMS; k++) begin
      if ((CW'(k) < num_terms) && (digits[4*k +: 4] > 4'd9)) begin
        start_legal = 1'b0;
      end
    end
  end

  // Operand and operator lookups from the captured copies. A compare loop is
  // used instead of a variable bit-select so the index width never has to
  // match the vector's natural index width.
  always_comb begin
    idx_next   = idx + CW'(1);
    op_sel     = 1'b0;
    digit_next = 4'd0;
    for (int k = 0; k < MAX_TERMS - 1; k++) begin
      if (idx == CW'(k)) begin
        op_sel = ops_q[k];
      end
    end
    for (int k = 0; k < MAX_TERMS; k++) begin
      if (idx_next == CW'(k)) begin
        digit_next = digits_q[4*k +: 4];
      end
    end
  end

  assign last_term = (idx == nt_q - CW'(1));

  // A legal digit is at most 9, so 8'h30 + d is the same as {4'h3, d}.
  // NOTE: all state uses non-blocking assignments. The outputs and the next
  // state are then computed from values that were sampled before the edge.
  // NOTE: the captured expression registers are cleared on reset as well, so
  // no stale operand survives a clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      idx       <= '0;
      nt_q      <= '0;
      digits_q  <= '0;
      ops_q     <= '0;
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_legal) begin
              digits_q  <= digits;
              ops_q     <= ops;
              nt_q      <= num_terms;
              idx       <= '0;
              state     <= NUM;
              out_char  <= {4'h3, digits[3:0]};
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        NUM: begin
          if (out_ready) begin
            if (last_term) begin
              state     <= IDLE;
              out_char  <= 8'h00;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              state    <= OP;
              out_char <= op_sel ? CHAR_MUL : CHAR_PLUS;
            end
          end
        end

        OP: begin
          if (out_ready) begin
            idx      <= idx_next;
            state    <= NUM;
            out_char <= {4'h3, digit_next};
          end
        end

        default: begin
          state     <= IDLE;
          out_char  <= 8'h00;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
